// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//
// Producer-side hazard controller for the 5-stage pipeline. It keeps shadow
// copies of the destination register and write/load flags of the EX and MEM
// stage instructions. These copies feed the forwarding unit. The unit also
// detects the hazards that forwarding cannot cover:
//   - load-use
//   - HI/LO access or mult/div issue while the mult/div unit is busy
//   - taken-branch squash
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   IDrs, IDrt     source register fields of the ID instruction
//   IDusesRt       ID instruction actually reads rt
//   IDrd           resolved destination of the ID instruction
//   IDregWrite     ID instruction writes the register file
//   IDmemRead      ID instruction is a load
//   IDmulDiv       ID instruction is mult/multu/div/divu
//   IDreadsHiLo    ID instruction is mfhi/mflo
//   branchTaken    branch/jump resolved taken in EX this cycle
//   stall          hold PC and IF/ID
//   bubble         zero the control fields entering ID/EX
//   flush          clear IF/ID
//   EXrd/EXregWrite, MEMrd/MEMregWrite   shadow pipeline state
//   mdBusy         mult/div unit busy
//   hazardCount    saturating count of stall cycles
module hazard_stall_unit #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic        IDusesRt,
    input  logic [4:0]  IDrd,
    input  logic        IDregWrite,
    input  logic        IDmemRead,
    input  logic        IDmulDiv,
    input  logic        IDreadsHiLo,
    input  logic        branchTaken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [4:0]  EXrd,
    output logic        EXregWrite,
    output logic [4:0]  MEMrd,
    output logic        MEMregWrite,
    output logic        mdBusy,
    output logic [15:0] hazardCount
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

    logic [4:0]  exRd;
    logic        exRegWrite;
    logic        exMemRead;
    logic [4:0]  memRd;
    logic        memRegWrite;
    logic [3:0]  mdCount;

    logic loadUse;
    logic mdHaz;

    assign EXrd        = exRd;
    assign EXregWrite  = exRegWrite;
    assign MEMrd       = memRd;
    assign MEMregWrite = memRegWrite;
    assign mdBusy      = (mdCount != 4'd0);

    // Register $0 is never a hazard source. rt only counts when it is really read.
    always_comb begin
        loadUse = exMemRead && exRegWrite && (exRd != 5'd0) &&
                  ((exRd == IDrs) || (IDusesRt && (exRd == IDrt)));
        mdHaz   = mdBusy && (IDreadsHiLo || IDmulDiv);
    end

    // A taken branch squashes the ID instruction. A squash never needs to
    // stall, so it masks both stall sources. All three are held low in reset.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (rst_n) begin
            if (branchTaken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (loadUse || mdHaz) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // Shadow EX/MEM pipeline state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exRd        <= '0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            memRd       <= '0;
            memRegWrite <= 1'b0;
        end else begin
            memRd       <= exRd;
            memRegWrite <= exRegWrite;
            if (bubble) begin
                exRd       <= '0;
                exRegWrite <= 1'b0;
                exMemRead  <= 1'b0;
            end else begin
                exRd       <= IDrd;
                exRegWrite <= IDregWrite;
                exMemRead  <= IDmemRead;
            end
        end
    end

    // Only a mult/div that actually leaves ID (no bubble) starts the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCount <= '0;
        end else if (IDmulDiv && !bubble) begin
            mdCount <= MD_LOAD;
        end else if (mdCount != 4'd0) begin
            mdCount <= mdCount - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazardCount <= '0;
        end else if (stall && (hazardCount != '1)) begin
            hazardCount <= hazardCount + 16'd1;
        end
    end

endmodule
